block_copy_dma: RTL and testbench

BLOCK_COPY_DMA -- requirements
Module: block_copy_dma

---
 rtl/block_copy_dma.sv | 109 ++++++++++
 tb/tb_block_copy_dma.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/block_copy_dma.sv
// Forward byte-by-byte memory copy engine driving a single synchronous RAM port.
// Each byte takes one READ cycle followed by one WRITE cycle.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for Start; memory port parked at zero
// S_READ  | source address on the bus, read data returns next cycle
// S_WRITE | destination address on the bus, writes the byte just read
// S_DONE  | one-cycle Done pulse, then back to idle
module block_copy_dma #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              Start,
    input  logic              Abort,
    input  logic [ADDR_W-1:0] SrcAddr,
    input  logic [ADDR_W-1:0] DstAddr,
    input  logic [ADDR_W-1:0] Length,
    output logic              Busy,
    output logic              Done,
    output logic              MemWE,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        Busy        = 1'b0;
        Done        = 1'b0;
        MemWE       = 1'b0;
        MemAddress  = '0;
        MemWData    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    src_ptr_d   = SrcAddr;
                    dst_ptr_d   = DstAddr;
                    remaining_d = Length;
                    state_d     = (Length != '0) ? S_READ : S_DONE;
                end
            end

            S_READ: begin
                Busy       = 1'b1;
                MemAddress = src_ptr_q;
                state_d    = Abort ? S_IDLE : S_WRITE;
            end

            S_WRITE: begin
                Busy        = 1'b1;
                MemWE       = 1'b1;
                MemAddress  = dst_ptr_q;
                MemWData    = MemRData;
                src_ptr_d   = src_ptr_q + ADDR_W'(1);
                dst_ptr_d   = dst_ptr_q + ADDR_W'(1);
                remaining_d = remaining_q - ADDR_W'(1);
                // Abort wins over the final-byte transition so no Done follows it.
                if (Abort)
                    state_d = S_IDLE;
                else if (remaining_q == ADDR_W'(1))
                    state_d = S_DONE;
                else
                    state_d = S_READ;
            end

            S_DONE: begin
                Busy    = 1'b1;
                Done    = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_block_copy_dma.sv
// Bench for block_copy_dma: synchronous RAM, per-cycle bus model keyed by edge number,
// and literal checks on final memory contents, Done timing and read-address order.
module tb_block_copy_dma;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam logic [1:0] K_IDLE = 2'd0, K_READ = 2'd1, K_WRITE = 2'd2, K_DONE = 2'd3;

    typedef struct packed {
        logic [1:0]    kind;
        logic [AW-1:0] addr;
    } entry_t;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          Start = 1'b0;
    logic          Abort = 1'b0;
    logic [AW-1:0] SrcAddr = '0, DstAddr = '0, Length = '0;
    logic          Busy, Done, MemWE;
    logic [AW-1:0] MemAddress;
    logic [DW-1:0] MemWData;
    logic [DW-1:0] MemRData = '0;

    block_copy_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .Start(Start), .Abort(Abort),
        .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length),
        .Busy(Busy), .Done(Done), .MemWE(MemWE), .MemAddress(MemAddress),
        .MemWData(MemWData), .MemRData(MemRData)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] mem    [0:65535];
    logic [DW-1:0] shadow [0:65535];
    entry_t        exp_q  [int];
    int            cyc = 0;
    int            chk_cnt = 0, pass_cnt = 0;
    int            done_cnt = 0, last_done = -1, we_cnt = 0;
    logic [AW-1:0] rd_log [$];

    always @(posedge CLK) begin
        if (MemWE) mem[MemAddress] <= MemWData;
        MemRData <= mem[MemAddress];
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        chk_cnt++;
        if (act === want) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, want, cyc);
    endtask

    // Model: the period after edge e shows the bus action scheduled for e, or idle.
    logic [DW-1:0] rd_val = '0;
    always @(negedge CLK) begin
        entry_t        e;
        logic [AW+DW+2:0] want;
        e = exp_q.exists(cyc) ? exp_q[cyc] : '0;
        case (e.kind)
            K_READ: begin
                want   = {1'b1, 1'b0, 1'b0, e.addr, 8'h00};
                rd_val = shadow[e.addr];
            end
            K_WRITE: begin
                want = {1'b1, 1'b0, 1'b1, e.addr, rd_val};
                shadow[e.addr] = rd_val;
            end
            K_DONE:  want = {1'b1, 1'b1, 1'b0, 16'h0, 8'h00};
            default: want = '0;
        endcase
        chk("bus", {Busy, Done, MemWE, MemAddress, MemWData}, 64'(want));
        if (Done) begin done_cnt++; last_done = cyc; end
        if (MemWE) we_cnt++;
        if (Busy && !MemWE && !Done) rd_log.push_back(MemAddress);
    end

    task automatic edge1();
        @(posedge CLK); #1;
    endtask

    task automatic drop_after(input int e);
        int keys[$];
        foreach (exp_q[k]) if (k > e) keys.push_back(k);
        foreach (keys[i]) exp_q.delete(keys[i]);
    endtask

    // Called just after an edge; Start is sampled at the next edge t.
    task automatic start_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                              input logic [AW-1:0] l, output int t);
        Start = 1'b1; SrcAddr = s; DstAddr = d; Length = l;
        t = cyc + 1;
        for (int k = 0; k < int'(l); k++) begin
            exp_q[t + 2*k]     = '{K_READ,  AW'(s + AW'(k))};
            exp_q[t + 2*k + 1] = '{K_WRITE, AW'(d + AW'(k))};
        end
        exp_q[t + 2*int'(l)] = '{K_DONE, '0};
        edge1();
        Start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 200) begin edge1(); n++; end
        if (n >= 200) chk("idle_timeout", 64'(1), 64'(0));
        edge1();
    endtask

    initial begin
        int t, d0, w0;
        for (int i = 0; i < 65536; i++) begin mem[i] = '0; shadow[i] = '0; end
        mem[16'h0100] = 8'hAA; mem[16'h0101] = 8'hBB; mem[16'h0102] = 8'hCC;
        mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22;
        mem[16'h0010] = 8'h05;
        for (int i = 0; i < 4; i++) begin
            mem[16'h0020 + i] = 8'h31 + 8'(i);
            mem[16'h0070 + i] = 8'h51 + 8'(i);
        end
        for (int i = 0; i < 3; i++) mem[16'h0050 + i] = 8'h41 + 8'(i);
        mem[16'h00A0] = 8'h77;
        for (int i = 0; i < 65536; i++) shadow[i] = mem[i];

        #2 chk("reset_outputs", {Busy, Done, MemWE, MemAddress, MemWData}, 64'(0));
        repeat (3) edge1();

        // Basic copy, Start accepted at the first edge after release
        RESET_N = 1'b1;
        d0 = done_cnt;
        start_copy(16'h0100, 16'h0200, 16'd3, t);
        wait_idle();
        chk("basic_m0", mem[16'h0200], 8'hAA);
        chk("basic_m1", mem[16'h0201], 8'hBB);
        chk("basic_m2", mem[16'h0202], 8'hCC);
        chk("basic_done_edge", 64'(last_done - t), 64'(6));
        chk("basic_done_cnt", 64'(done_cnt - d0), 64'(1));

        // Zero length
        w0 = we_cnt; d0 = done_cnt;
        start_copy(16'h0500, 16'h0600, 16'd0, t);
        wait_idle();
        chk("zero_we", 64'(we_cnt - w0), 64'(0));
        chk("zero_done_edge", 64'(last_done - t), 64'(0));
        chk("zero_done_cnt", 64'(done_cnt - d0), 64'(1));

        // Address wrap
        rd_log.delete();
        start_copy(16'hFFFF, 16'h0300, 16'd2, t);
        wait_idle();
        chk("wrap_m0", mem[16'h0300], 8'h11);
        chk("wrap_m1", mem[16'h0301], 8'h22);
        chk("wrap_nrd", 64'(rd_log.size()), 64'(2));
        if (rd_log.size() == 2) begin
            chk("wrap_rd0", rd_log[0], 16'hFFFF);
            chk("wrap_rd1", rd_log[1], 16'h0000);
        end

        // Overlapping forward copy replicates the first byte
        start_copy(16'h0010, 16'h0011, 16'd3, t);
        wait_idle();
        chk("ovl_m1", mem[16'h0011], 8'h05);
        chk("ovl_m2", mem[16'h0012], 8'h05);
        chk("ovl_m3", mem[16'h0013], 8'h05);

        // Start while busy is ignored
        rd_log.delete(); d0 = done_cnt;
        start_copy(16'h0020, 16'h0040, 16'd4, t);
        Start = 1'b1; SrcAddr = 16'h0400; DstAddr = 16'h0500; Length = 16'd4;
        edge1();
        Start = 1'b0;
        wait_idle();
        chk("busy_done_cnt", 64'(done_cnt - d0), 64'(1));
        chk("busy_nrd", 64'(rd_log.size()), 64'(4));
        if (rd_log.size() == 4) chk("busy_rd3", rd_log[3], 16'h0023);
        chk("busy_m3", mem[16'h0043], 8'h34);
        chk("busy_2nd_dst", mem[16'h0500], 8'h00);

        // Abort during the first WRITE: that write completes, nothing after it
        d0 = done_cnt;
        start_copy(16'h0050, 16'h0060, 16'd3, t);
        edge1();
        Abort = 1'b1; drop_after(cyc);
        edge1();
        Abort = 1'b0;
        repeat (4) edge1();
        chk("abort_m0", mem[16'h0060], 8'h41);
        chk("abort_m1", mem[16'h0061], 8'h00);
        chk("abort_done", 64'(done_cnt - d0), 64'(0));

        // Abort coinciding with the final WRITE suppresses Done
        d0 = done_cnt;
        start_copy(16'h00A0, 16'h00B0, 16'd1, t);
        edge1();
        Abort = 1'b1; drop_after(cyc);
        edge1();
        Abort = 1'b0;
        repeat (3) edge1();
        chk("abort_last_m", mem[16'h00B0], 8'h77);
        chk("abort_last_done", 64'(done_cnt - d0), 64'(0));

        // Abort held through IDLE and DONE has no effect
        d0 = done_cnt;
        Abort = 1'b1;
        start_copy(16'h0000, 16'h0000, 16'd0, t);
        edge1();
        Abort = 1'b0;
        edge1();
        chk("abort_idle_done", 64'(done_cnt - d0), 64'(1));

        // Reset in the second WRITE of a 4-byte copy
        d0 = done_cnt;
        start_copy(16'h0070, 16'h0080, 16'd4, t);
        repeat (3) edge1();
        drop_after(cyc - 1);
        #1 RESET_N = 1'b0;
        #1 chk("rst_async", {Busy, Done, MemWE, MemAddress, MemWData}, 64'(0));
        repeat (2) edge1();
        RESET_N = 1'b1;
        chk("rst_m0", mem[16'h0080], 8'h51);
        chk("rst_m1", mem[16'h0081], 8'h00);
        chk("rst_done", 64'(done_cnt - d0), 64'(0));
        start_copy(16'h0070, 16'h0090, 16'd2, t);
        wait_idle();
        chk("post_rst_m0", mem[16'h0090], 8'h51);
        chk("post_rst_m1", mem[16'h0091], 8'h52);
        chk("post_rst_done_edge", 64'(last_done - t), 64'(4));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
